// File: rtl/mmio_test_port.sv
// ---------------------------------------------------------------------------
// mmio_test_port
//
// Test and console peripheral on the core's data-memory bus. It decodes a
// 16-byte window at BASE_ADDR that holds four word registers:
//   0x0 TOHOST   : write {code, 1} to finish the run; reads {code, done}
//   0x4 CONSOLE  : write pushes a byte into the TX FIFO; reads
//                  {overflow, 0..., count}
//   0x8 CYCLE_LO : low word of the free-running cycle counter
//   0xC CYCLE_HI : high word of the free-running cycle counter
//
// Parameters
//   BASE_ADDR  : byte address of the window (16-byte aligned)
//   FIFO_DEPTH : console FIFO entries (power of two, >= 2)
//
// Ports
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_Addr, i_Wd        : bus byte address and write data
//   i_Ren, i_Wen        : bus read / write enables
//   o_Rd, o_Hit         : combinational read data and window hit
//   o_Done, o_Pass      : sticky completion flag and pass status
//   o_Code              : latched completion code
//   o_TxData, o_TxValid : console FIFO head byte and non-empty flag
//   i_TxReady           : consumer accepts the head byte
// ---------------------------------------------------------------------------
module mmio_test_port #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_Addr,
    input  logic [31:0] i_Wd,
    input  logic        i_Ren,
    input  logic        i_Wen,
    output logic [31:0] o_Rd,
    output logic        o_Hit,
    output logic        o_Done,
    output logic        o_Pass,
    output logic [30:0] o_Code,
    output logic [7:0]  o_TxData,
    output logic        o_TxValid,
    input  logic        i_TxReady
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        REG_TOHOST   = 2'd0,
        REG_CONSOLE  = 2'd1,
        REG_CYCLE_LO = 2'd2,
        REG_CYCLE_HI = 2'd3
    } reg_sel_e;

    // Bus decode
    reg_sel_e sel;
    logic     wr_en;
    logic     tohost_wr;
    logic     console_wr;

    // Completion and cycle counter state
    logic        done;
    logic        pass;
    logic [30:0] code;
    logic [63:0] cycle;

    // Console FIFO state
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          tx_valid;
    logic          full;
    logic          pop;
    logic          push;

    // Sub-word address bits carry no meaning: every access is a full word.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^i_Addr[1:0];

    assign o_Hit      = (i_Addr[31:4] == BASE_ADDR[31:4]);
    assign sel        = reg_sel_e'(i_Addr[3:2]);
    assign wr_en      = o_Hit & i_Wen;
    // Only a write with bit 0 set completes, and only the first one counts.
    assign tohost_wr  = wr_en && (sel == REG_TOHOST) && i_Wd[0] && !done;
    assign console_wr = wr_en && (sel == REG_CONSOLE);

    assign tx_valid = (count != '0);
    assign full     = (count == FULL_COUNT);
    assign pop      = tx_valid & i_TxReady;
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign push     = console_wr & (~full | pop);

    // -----------------------------------------------------------------------
    // TOHOST completion latch
    // -----------------------------------------------------------------------
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values, independent of block ordering.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            done <= 1'b0;
            pass <= 1'b0;
            code <= '0;
        end else if (tohost_wr) begin
            done <= 1'b1;
            pass <= (i_Wd[31:1] == 31'd0);
            code <= i_Wd[31:1];
        end
    end

    // -----------------------------------------------------------------------
    // Cycle counter: runs until completion, then freezes for post-mortem.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cycle <= '0;
        end else if (!done) begin
            cycle <= cycle + 64'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Console FIFO control
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A dropped byte is remembered until the next reset.
            if (console_wr && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset; an empty FIFO never exposes it
    // because the head byte is gated by tx_valid below.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_Wd[7:0];
        end
    end

    assign o_TxValid = tx_valid;
    assign o_TxData  = tx_valid ? mem[rd_ptr] : 8'h00;

    assign o_Done = done;
    assign o_Pass = pass;
    assign o_Code = code;

    // -----------------------------------------------------------------------
    // Read mux
    // -----------------------------------------------------------------------
    // NOTE: o_Rd gets a default before the case so no latch is inferred.
    always_comb begin
        o_Rd = '0;
        if (o_Hit && i_Ren) begin
            case (sel)
                REG_TOHOST:   o_Rd = {code, done};
                REG_CONSOLE:  o_Rd = {overflow, 31'(count)};
                REG_CYCLE_LO: o_Rd = cycle[31:0];
                REG_CYCLE_HI: o_Rd = cycle[63:32];
                default:      o_Rd = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_test_port.sv
// ---------------------------------------------------------------------------
// tb_mmio_test_port
//
// Self-checking bench for mmio_test_port: a table of single-cycle bus
// vectors with hand-computed results, followed by hand-written sequences
// for completion codes, FIFO overflow, full-FIFO push/pop and mid-drain
// reset.
// ---------------------------------------------------------------------------
module tb_mmio_test_port;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_Addr;
    logic [31:0] i_Wd;
    logic        i_Ren;
    logic        i_Wen;
    logic [31:0] o_Rd;
    logic        o_Hit;
    logic        o_Done;
    logic        o_Pass;
    logic [30:0] o_Code;
    logic [7:0]  o_TxData;
    logic        o_TxValid;
    logic        i_TxReady;

    int n_checks = 0;
    int n_fail   = 0;

    mmio_test_port #(
        .BASE_ADDR  (32'h0000_1000),
        .FIFO_DEPTH (8)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_Addr    (i_Addr),
        .i_Wd      (i_Wd),
        .i_Ren     (i_Ren),
        .i_Wen     (i_Wen),
        .o_Rd      (o_Rd),
        .o_Hit     (o_Hit),
        .o_Done    (o_Done),
        .o_Pass    (o_Pass),
        .o_Code    (o_Code),
        .o_TxData  (o_TxData),
        .o_TxValid (o_TxValid),
        .i_TxReady (i_TxReady)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        logic        ren;
        logic        wen;
        logic        rdy;
        logic [31:0] exp_rd;     // before the edge
        logic        exp_hit;    // before the edge
        logic        exp_done;   // after the edge
        logic        exp_pass;
        logic [30:0] exp_code;
        logic        exp_valid;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] addr, input logic [31:0] wd,
                         input logic ren, input logic wen);
        i_Addr = addr;
        i_Wd   = wd;
        i_Ren  = ren;
        i_Wen  = wen;
    endtask

    task automatic bus_idle();
        drive(32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic write_word(input logic [31:0] addr, input logic [31:0] wd);
        drive(addr, wd, 1'b0, 1'b1);
        tick();
        bus_idle();
    endtask

    // Drive a read, compare the combinational result, then let a cycle pass.
    task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        drive(addr, 32'h0, 1'b1, 1'b0);
        #1;
        check(name, o_Rd, exp);
        tick();
        bus_idle();
    endtask

    task automatic do_reset();
        bus_idle();
        i_TxReady = 1'b0;
        i_rst     = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{32'h1000, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 31'd0, 1'b0, 8'h00};
        vecs[1]  = '{32'h2004, 32'h55, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 31'd0, 1'b0, 8'h00};
        vecs[2]  = '{32'h1000, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 31'd0, 1'b0, 8'h00};
        vecs[3]  = '{32'h1004, 32'h33, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 31'd0, 1'b1, 8'h33};
        vecs[4]  = '{32'h1004, 32'h0,  1'b1, 1'b0, 1'b0, 32'h1, 1'b1, 1'b0, 1'b0, 31'd0, 1'b1, 8'h33};
        vecs[5]  = '{32'h1008, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 31'd0, 1'b1, 8'h33};
        vecs[6]  = '{32'h1000, 32'h1,  1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 31'd0, 1'b1, 8'h33};
        vecs[7]  = '{32'h1000, 32'h7,  1'b1, 1'b1, 1'b0, 32'h1, 1'b1, 1'b1, 1'b1, 31'd0, 1'b1, 8'h33};
        vecs[8]  = '{32'h1003, 32'h0,  1'b1, 1'b0, 1'b0, 32'h1, 1'b1, 1'b1, 1'b1, 31'd0, 1'b1, 8'h33};
        vecs[9]  = '{32'h1004, 32'h44, 1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 31'd0, 1'b1, 8'h44};
        vecs[10] = '{32'h0,    32'h0,  1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 31'd0, 1'b0, 8'h00};

        // ---------------- reset state ----------------
        do_reset();
        check("reset_done",    o_Done,    1'b0);
        check("reset_pass",    o_Pass,    1'b0);
        check("reset_code",    o_Code,    31'd0);
        check("reset_txvalid", o_TxValid, 1'b0);
        check("reset_txdata",  o_TxData,  8'h00);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].addr, vecs[i].wd, vecs[i].ren, vecs[i].wen);
            i_TxReady = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d_rd", i),  o_Rd,  vecs[i].exp_rd);
            check($sformatf("vec%0d_hit", i), o_Hit, vecs[i].exp_hit);
            tick();
            check($sformatf("vec%0d_done", i),  o_Done,    vecs[i].exp_done);
            check($sformatf("vec%0d_pass", i),  o_Pass,    vecs[i].exp_pass);
            check($sformatf("vec%0d_code", i),  o_Code,    vecs[i].exp_code);
            check($sformatf("vec%0d_valid", i), o_TxValid, vecs[i].exp_valid);
            check($sformatf("vec%0d_data", i),  o_TxData,  vecs[i].exp_data);
        end
        bus_idle();
        i_TxReady = 1'b0;

        // ---------------- failing completion code, frozen counter ----------------
        do_reset();
        read_check("cyc_lo_first", 32'h1008, 32'd0);   // counter becomes 1
        write_word(32'h1000, 32'h0000_0015);           // counter becomes 2, done
        check("fail_done", o_Done, 1'b1);
        check("fail_pass", o_Pass, 1'b0);
        check("fail_code", o_Code, 31'd10);
        read_check("fail_tohost", 32'h1000, 32'h15);
        for (int i = 0; i < 5; i++) begin
            read_check($sformatf("cyc_frozen%0d", i), 32'h1008, 32'd2);
        end
        read_check("cyc_hi", 32'h100C, 32'd0);

        // ---------------- overflow and drain ----------------
        do_reset();
        for (int i = 0; i < 9; i++) begin
            write_word(32'h1004, 32'h41 + i);
        end
        read_check("ovf_status", 32'h1004, 32'h8000_0008);
        i_TxReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d_valid", i), o_TxValid, 1'b1);
            check($sformatf("drain%0d_data", i),  o_TxData,  8'h41 + 8'(i));
            tick();
        end
        check("drain_empty", o_TxValid, 1'b0);
        read_check("ovf_sticky", 32'h1004, 32'h8000_0000);

        // ---------------- full FIFO with simultaneous push and pop ----------------
        do_reset();
        read_check("ovf_cleared", 32'h1004, 32'h0);
        for (int i = 0; i < 8; i++) begin
            write_word(32'h1004, 32'h60 + i);
        end
        check("full_head", o_TxData, 8'h60);
        i_TxReady = 1'b1;
        write_word(32'h1004, 32'h5A);
        i_TxReady = 1'b0;
        read_check("full_pushpop_status", 32'h1004, 32'h0000_0008);
        i_TxReady = 1'b1;
        for (int i = 0; i < 7; i++) begin
            check($sformatf("pp_drain%0d", i), o_TxData, 8'h61 + 8'(i));
            tick();
        end
        check("pp_last_valid", o_TxValid, 1'b1);
        check("pp_last_data",  o_TxData,  8'h5A);
        tick();
        check("pp_empty", o_TxValid, 1'b0);
        i_TxReady = 1'b0;

        // ---------------- reset mid-drain ----------------
        write_word(32'h1000, 32'h3);
        check("pre_rst_done", o_Done, 1'b1);
        for (int i = 0; i < 5; i++) begin
            write_word(32'h1004, 32'h70 + i);
        end
        i_TxReady = 1'b1;
        tick();
        tick();
        i_TxReady = 1'b0;
        read_check("pre_rst_status", 32'h1004, 32'h3);
        check("pre_rst_data", o_TxData, 8'h72);
        i_rst = 1'b1;                                   // mid-cycle, asynchronous
        #1;
        check("rst_txvalid", o_TxValid, 1'b0);
        check("rst_txdata",  o_TxData,  8'h00);
        check("rst_done",    o_Done,    1'b0);
        check("rst_code",    o_Code,    31'd0);
        drive(32'h1004, 32'h0, 1'b1, 1'b0);
        #1;
        check("rst_status", o_Rd, 32'h0);
        bus_idle();
        tick();
        i_rst = 1'b0;
        read_check("post_rst_cyc_lo", 32'h1008, 32'd0);
        read_check("post_rst_status", 32'h1004, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_test_port.md
# mmio_test_port

Memory-mapped test and console peripheral on the core's data-memory bus, alongside the data memory, decoded at a fixed base address. Captures the program's completion code (tohost-style), buffers console bytes in a small FIFO drained over a valid/ready port, and exposes a free-running 64-bit cycle counter. Simulation and FPGA harnesses use `o_Done`/`o_Pass` to end a run without peeking at core internals.

## Interface
- `BASE_ADDR`, default 32'h0000_1000: byte address of the 16-byte register window; must be 16-byte aligned.
- `FIFO_DEPTH`, default 8: console FIFO entries; power of two, ≥2.
- `i_clk`  in  1  core clock; all state updates on rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_Addr`  in  32  data-bus byte address.
- `i_Wd`  in  32  data-bus write data.
- `i_Ren`  in  1  data-bus read enable.
- `i_Wen`  in  1  data-bus write enable.
- `o_Rd`  out  32  read data; combinational.
- `o_Hit`  out  1  address is within the window (the datapath selects `o_Rd` over data memory); combinational.
- `o_Done`  out  1  sticky; completion written.
- `o_Pass`  out  1  valid when `o_Done`=1; 1 iff the completion code is 0.
- `o_Code`  out  31  latched completion code.
- `o_TxData`  out  8  FIFO head byte.
- `o_TxValid`  out  1  FIFO non-empty.
- `i_TxReady`  in  1  consumer accepts the head byte when `o_TxValid`=1.

## Operation
- Decode: `o_Hit` = (`i_Addr`[31:4] == `BASE_ADDR`[31:4]). Register select is `i_Addr`[3:2]. `i_Addr`[1:0] are ignored; all accesses are full-word.
- Offset 0x0, TOHOST:
  - Write with `i_Wd`[0]=1 while `o_Done`=0 sets `o_Done`=1 and latches `o_Code`=`i_Wd`[31:1]. `o_Pass`=(`o_Code`==0).
  - Writes with `i_Wd`[0]=0 are ignored.
  - All writes after `o_Done`=1 are ignored. First completion wins.
  - Read returns {`o_Code`, `o_Done`}.
- Offset 0x4, CONSOLE:
  - A write pushes `i_Wd`[7:0].
  - If the FIFO is full and no pop occurs that cycle, the byte is dropped and sticky `overflow` is set.
  - Read returns {`overflow`, 26'b0, count}, with count (0..FIFO_DEPTH) in bits [4:0]. With FIFO_DEPTH > 16, count widens into the zero field.
  - `overflow` clears only on reset.
- Offset 0x8 / 0xC, CYCLE_LO / CYCLE_HI:
  - 64-bit counter; increments every cycle while `o_Done`=0 and freezes once `o_Done`=1.
  - Writes are ignored.
  - LO and HI are read independently. Software handles carry by re-reading.
- `o_Rd` = selected register when `o_Hit` & `i_Ren`, else 0.
- Writes occur only when `o_Hit` & `i_Wen`. Out-of-window accesses have no effect.
- FIFO:
  - Circular buffer with read pointer, write pointer and count.
  - Pop = `o_TxValid` & `i_TxReady`; head advances on that edge.
  - Push when full is accepted only if a pop occurs the same cycle (count unchanged).
  - Push and pop on a non-full, non-empty FIFO leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - No bypass: a byte pushed into an empty FIFO appears on `o_TxData` the next cycle.

## Timing
- Reset (async assert, any cycle, including mid-drain): `o_Done`=0, `o_Pass`=0, `o_Code`=0, `o_TxValid`=0, `o_TxData`=0, counter=0, FIFO empty, `overflow`=0. `o_Rd`/`o_Hit` follow the inputs.
- Write latency is 1 edge. A read in the same cycle as a write to the same register returns the pre-write value.
- Counter reads value N in the cycle when it holds N. The first cycle after reset deassertion reads 0.
- `o_Done` rises the cycle after the completing write edge. The counter holds its value from that edge on.
- `o_TxData` is stable while `o_TxValid`=1 and `i_TxReady`=0. Valid never drops without a pop.

## Test plan
- Reset then write 32'h1 to 0x1000 → next cycle `o_Done`=1, `o_Pass`=1, `o_Code`=0; a later write of 32'h7 → still `o_Code`=0.
- Write 32'h0000_0015 to TOHOST → `o_Done`=1, `o_Pass`=0, `o_Code`=10. Read 0x1000 → 32'h15. CYCLE_LO is frozen across 5 further reads.
- With `i_TxReady`=0, write bytes 0x41..0x49 (9 writes) to 0x1004 → FIFO count=8, `overflow`=1, status read = 32'h8000_0008. Then raise ready → bytes 0x41..0x48 emitted in order, then `o_TxValid`=0.
- FIFO full with `i_TxReady`=1 and a simultaneous push of 0x5A → no overflow; count stays 8; 0x5A emerges last.
- Assert `i_rst` mid-drain (count=3) → `o_TxValid`=0 immediately, status read = 0, CYCLE_LO = 0 on first post-reset cycle.
- Access 0x2004 with `i_Wen`=1 → `o_Hit`=0, FIFO unchanged. Read 0x1008 with `i_Ren`=0 → `o_Rd`=0.
